// File: rtl/adder_seq_pkg.sv
// Shared constants and state encoding for the chunked add sequencer.
package adder_seq_pkg;

  localparam int unsigned SLICE_W = 4;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ADD  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  typedef enum logic [1:0] {
    StIdle = IDLE,
    StAdd  = ADD,
    StDone = DONE
  } state_e;

endpackage

// File: rtl/rippleAdder.sv
// 4-bit ripple-carry adder slice, shared by the sequencer.
module rippleAdder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [4:0] carry;

  assign carry[0] = cin;

  for (genvar i = 0; i < 4; i++) begin : g_fa
    assign sum[i]     = a[i] ^ b[i] ^ carry[i];
    assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
  end

  assign cout = carry[4];

endmodule

// File: rtl/chunked_add_sequencer.sv
// Adds two wide operands through one shared 4-bit ripple slice, LSB slice first,
// with valid/ready handshakes on operand accept and result return.
module chunked_add_sequencer
  import adder_seq_pkg::*;
#(
  parameter int unsigned WORDS = 4,
  parameter int unsigned CNT_W = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start_valid,
  output logic                       start_ready,
  input  logic [SLICE_W*WORDS-1:0]   a,
  input  logic [SLICE_W*WORDS-1:0]   b,
  input  logic                       cin,
  output logic                       result_valid,
  input  logic                       result_ready,
  output logic [SLICE_W*WORDS-1:0]   sum,
  output logic                       cout,
  output logic                       busy
);

  localparam int unsigned OpW = SLICE_W * WORDS;
  localparam logic [CNT_W-1:0] LastIdx = CNT_W'(WORDS - 1);

  state_e           state_q, state_d;
  logic [OpW-1:0]   a_q, a_d;
  logic [OpW-1:0]   b_q, b_d;
  logic [OpW-1:0]   sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CNT_W-1:0] idx_q, idx_d;

  logic [SLICE_W-1:0]     slice_sum;
  logic                   slice_cout;
  logic [OpW+SLICE_W-1:0] sum_ext;

  rippleAdder u_slice (
    .a    (a_q[SLICE_W-1:0]),
    .b    (b_q[SLICE_W-1:0]),
    .cin  (carry_q),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  // New nibble enters at the top; after WORDS shifts the LSB slice sits at bit 0.
  assign sum_ext = {slice_sum, sum_q};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    idx_d   = idx_q;
    unique case (state_q)
      StIdle: begin
        if (start_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          idx_d   = '0;
          sum_d   = '0;
          state_d = StAdd;
        end
      end
      StAdd: begin
        sum_d   = sum_ext[OpW+SLICE_W-1:SLICE_W];
        a_d     = a_q >> SLICE_W;
        b_d     = b_q >> SLICE_W;
        carry_d = slice_cout;
        idx_d   = idx_q + 1'b1;
        if (idx_q == LastIdx) begin
          cout_d  = slice_cout;
          state_d = StDone;
        end
      end
      StDone: begin
        if (result_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign start_ready  = (state_q == StIdle);
  assign result_valid = (state_q == StDone);
  assign busy         = (state_q == StAdd) || (state_q == StDone);
  assign sum          = sum_q;
  assign cout         = cout_q;

endmodule
